// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the MEM stage: word-addressed RAM, WAIT_CYCLES busy cycles per access.
// Optional misaligned-access detection is compiled in with `define DMEM_ALIGN_CHECK_EN.
module dmem_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable_i,
  input  logic        is_write_mem_i,
  input  logic [31:0] mem_address_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stall_req_o,
  output logic        done_o,
  output logic        align_err_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              mis_q, mis_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              aerr_q, aerr_d;
  logic [31:0]       mem_q [DEPTH];

  logic [ADDR_W-1:0] req_idx;
  logic              req_mis;
  logic              fire;
  logic [ADDR_W-1:0] acc_idx;
  logic [31:0]       acc_wdata;
  logic              acc_we;
  logic              acc_mis;
  logic              unused_addr;

  assign req_idx     = mem_address_i[ADDR_W+1:2];
  assign unused_addr = ^{mem_address_i[31:ADDR_W+2], mem_address_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign req_mis = |mem_address_i[1:0];
`else
  assign req_mis = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    mis_d     = mis_q;
    fire      = 1'b0;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_we    = we_q;
    acc_mis   = mis_q;

    case (state_q)
      IDLE: begin
        if (mem_enable_i) begin
          idx_d   = req_idx;
          wdata_d = mem_data_i;
          we_d    = is_write_mem_i;
          mis_d   = req_mis;
          if (WAIT_CYCLES > 0) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            // Zero wait states: the access completes on the accepting edge, straight from the inputs.
            state_d   = DONE;
            fire      = 1'b1;
            acc_idx   = req_idx;
            acc_wdata = mem_data_i;
            acc_we    = is_write_mem_i;
            acc_mis   = req_mis;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          fire    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdata_d = rdata_q;
    aerr_d  = 1'b0;
    if (fire) begin
      aerr_d = acc_mis;
      if (!acc_we) begin
        rdata_d = acc_mis ? 32'h0 : mem_q[acc_idx];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= 32'h0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
      aerr_q  <= aerr_d;
    end
  end

  // NOTE: the RAM array has no reset; reset only blocks a pending store so an aborted sw never lands.
  always_ff @(posedge clk) begin
    if (!reset && fire && acc_we && !acc_mis) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign mem_data_o  = rdata_q;
  assign done_o      = (state_q == DONE);
  assign stall_req_o = !reset && (((state_q == IDLE) && mem_enable_i) || (state_q == BUSY));

`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err_o = aerr_q;
`else
  // Without the check req_mis is 0, so aerr_q can never set; the port is tied off explicitly.
  assign align_err_o = 1'b0;
  logic unused_aerr;
  assign unused_aerr = aerr_q;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a word-array reference model predicts each response at issue time,
// and an independent monitor compares read data, align flag and stall length on every done_o pulse.
module tb_dmem_ctrl;
  localparam int ADDR_W       = 10;
  localparam int WAIT         = 2;
  localparam int DEPTH        = 2 ** ADDR_W;
  localparam int CYCLE_BUDGET = 64;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable_i;
  logic        is_write_mem_i;
  logic [31:0] mem_address_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        stall_req_o;
  logic        done_o;
  logic        align_err_o;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_enable_i   (mem_enable_i),
    .is_write_mem_i (is_write_mem_i),
    .mem_address_i  (mem_address_i),
    .mem_data_i     (mem_data_i),
    .mem_data_o     (mem_data_o),
    .stall_req_o    (stall_req_o),
    .done_o         (done_o),
    .align_err_o    (align_err_o)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        aerr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [int];
  logic [31:0] last_load = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit misaligned(input logic [31:0] a);
    return ALIGN_EN && (a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] mk_addr(input int idx, input logic [1:0] low);
    logic [31:0] hi;
    hi = $urandom();
    hi[ADDR_W+1:0] = '0;
    return hi | (32'(idx) << 2) | 32'(low);
  endfunction

  task automatic scramble();
    mem_enable_i   = 1'($urandom());
    is_write_mem_i = 1'($urandom());
    mem_address_i  = $urandom();
    mem_data_i     = $urandom();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      scramble();
      mem_enable_i = 1'b0;
      @(posedge clk); #1;
      check("idle_stall", stall_req_o, 0);
    end
  endtask

  // Predict the response, present the request in IDLE, and return in the IDLE cycle after DONE.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    bit   seen;
    bit   mis;
    seen   = 1'b0;
    mis    = misaligned(addr);
    e.aerr = mis;
    if (we) begin
      if (!mis) model_mem[widx(addr)] = data;
    end else begin
      if (mis) last_load = 32'h0;
      else if (model_mem.exists(widx(addr))) last_load = model_mem[widx(addr)];
      else last_load = 32'hxxxx_xxxx;
    end
    e.rdata = last_load;
    exp_q.push_back(e);

    mem_enable_i   = 1'b1;
    is_write_mem_i = we;
    mem_address_i  = addr;
    mem_data_i     = data;
    for (int i = 0; i < CYCLE_BUDGET && !seen; i++) begin
      @(posedge clk); #1;
      scramble();
      seen = done_o;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done_o within %0d cycles for addr 0x%08h", CYCLE_BUDGET, addr);
      exp_q.delete();
    end
    @(posedge clk); #1;
    mem_enable_i = 1'b0;
  endtask

  task automatic reset_with_request(input int n, input logic [31:0] addr, input logic [31:0] data);
    reset          = 1'b1;
    mem_enable_i   = 1'b1;
    is_write_mem_i = 1'b1;
    mem_address_i  = addr;
    mem_data_i     = data;
    #1;
    check("rst_stall_comb", stall_req_o, 0);
    repeat (n) begin
      @(posedge clk); #1;
      check("rst_stall", stall_req_o, 0);
      check("rst_rdata", mem_data_o, 0);
      check("rst_done", done_o, 0);
      check("rst_align", align_err_o, 0);
    end
    reset        = 1'b0;
    mem_enable_i = 1'b0;
    last_load    = 32'h0;
    @(posedge clk); #1;
    check("post_rst_stall", stall_req_o, 0);
  endtask

  initial begin : monitor
    forever begin
      exp_t e;
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0;
      end else begin
        if (stall_req_o) stall_cnt++;
        if (done_o) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", done_o, 0);
          end else begin
            e = exp_q.pop_front();
            check("rdata", mem_data_o, e.rdata);
            check("align_err", align_err_o, e.aerr);
            check("stall_len", stall_cnt, 1 + WAIT);
          end
          stall_cnt = 0;
        end
      end
    end
  end

  initial begin : stimulus
    reset_with_request(2, 32'h40, 32'hBAD0_BAD0);
    idle(3);

    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_0010, 32'h0);
    issue(1'b1, 32'h0000_0004, 32'h1234_5678);
    issue(1'b0, 32'h0000_0004, 32'h0);
    issue(1'b0, 32'h0000_0004, 32'h0);
    issue(1'b1, 32'h0000_1000, 32'hA5A5_A5A5);
    issue(1'b0, 32'h0000_0000, 32'h0);

    // Abort a store in its first BUSY cycle; the word must keep its preloaded value.
    issue(1'b1, 32'h0000_0020, 32'h0);
    issue(1'b1, 32'h0000_0008, 32'h0);
    mem_enable_i   = 1'b1;
    is_write_mem_i = 1'b1;
    mem_address_i  = 32'h0000_0020;
    mem_data_i     = 32'h1111_1111;
    @(posedge clk); #1;
    mem_enable_i = 1'b0;
    check("busy_stall", stall_req_o, 1);
    reset_with_request(1, 32'h0000_0020, 32'h1111_1111);
    issue(1'b0, 32'h0000_0020, 32'h0);

    issue(1'b1, 32'h0000_0009, 32'hFFFF_FFFF);
    issue(1'b0, 32'h0000_0008, 32'h0);
    issue(1'b0, 32'h0000_0009, 32'h0);

    reset_with_request(2, 32'h0000_0008, 32'h7777_7777);
    issue(1'b0, 32'h0000_0008, 32'h0);

    for (int k = 0; k < 8; k++) issue(1'b1, mk_addr(100 + 37 * k, 2'b00), $urandom());
    for (int n = 0; n < 150; n++) begin
      int          k;
      logic [1:0]  low;
      k   = $urandom_range(0, 7);
      low = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(1'($urandom()), mk_addr(100 + 37 * k, low), $urandom());
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    for (int i = 0; i < CYCLE_BUDGET && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses never observed", exp_q.size());
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
